// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI4-lite master-side channel bundle for the round-robin arbiter.
// The master modport drives requests; the slave modport is its mirror.
interface axi_lite_rr_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS requesters onto one AXI4-lite
// master; one transaction in flight, request fields latched at grant.
module axi_lite_rr_arbiter #(
   parameter int unsigned          NUM_PORTS       = 3,
   parameter int unsigned          ADDR_WIDTH      = 32,
   parameter int unsigned          DATA_WIDTH      = 32,
   parameter logic [NUM_PORTS-1:0] INSTR_PORT_MASK = NUM_PORTS'(1)
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [NUM_PORTS-1:0]             req_valid,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb,
   output logic [NUM_PORTS-1:0]             resp_valid,
   output logic [DATA_WIDTH-1:0]            resp_rdata,
   output logic                             resp_err,
   output logic [NUM_PORTS-1:0]             grant,
   axi_lite_rr_arbiter_if.master            m_axi
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] wstrb;
   } req_t;

   logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_PORTS];
   logic [STRB_WIDTH-1:0] w_wstrb_arr [NUM_PORTS];

   for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_unpack
      assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_wstrb_arr[g] = req_wstrb[g*STRB_WIDTH +: STRB_WIDTH];
   end

   state_t                r_state,      w_state;
   logic [PTR_W-1:0]      r_ptr,        w_ptr;
   logic [PTR_W-1:0]      r_port,       w_port;
   req_t                  r_req,        w_req;
   logic [2:0]            r_arprot,     w_arprot;
   logic                  r_arvalid,    w_arvalid;
   logic                  r_rready,     w_rready;
   logic                  r_awvalid,    w_awvalid;
   logic                  r_wvalid,     w_wvalid;
   logic                  r_bready,     w_bready;
   logic [NUM_PORTS-1:0]  r_grant,      w_grant;
   logic [NUM_PORTS-1:0]  r_resp_valid, w_resp_valid;
   logic [DATA_WIDTH-1:0] r_rdata,      w_rdata;
   logic                  r_err,        w_err;
   logic                  w_found;
   logic [PTR_W-1:0]      w_sel;
   logic [PTR_W-1:0]      w_cand;
   int                    w_idx;

   // State and all outputs are registered; AXI inputs only feed next-state logic.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_port       <= '0;
         r_req        <= '0;
         r_arprot     <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_grant      <= '0;
         r_resp_valid <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_ptr        <= w_ptr;
         r_port       <= w_port;
         r_req        <= w_req;
         r_arprot     <= w_arprot;
         r_arvalid    <= w_arvalid;
         r_rready     <= w_rready;
         r_awvalid    <= w_awvalid;
         r_wvalid     <= w_wvalid;
         r_bready     <= w_bready;
         r_grant      <= w_grant;
         r_resp_valid <= w_resp_valid;
         r_rdata      <= w_rdata;
         r_err        <= w_err;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_ptr        = r_ptr;
      w_port       = r_port;
      w_req        = r_req;
      w_arprot     = r_arprot;
      w_arvalid    = r_arvalid;
      w_rready     = r_rready;
      w_awvalid    = r_awvalid;
      w_wvalid     = r_wvalid;
      w_bready     = r_bready;
      w_grant      = r_grant;
      w_resp_valid = r_resp_valid;
      w_rdata      = r_rdata;
      w_err        = r_err;
      w_found      = 1'b0;
      w_sel        = r_ptr;
      w_cand       = r_ptr;
      w_idx        = 0;

      // First requester at or after the pointer, wrapping around.
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= int'(NUM_PORTS)) w_idx = w_idx - int'(NUM_PORTS);
         w_cand = PTR_W'(w_idx);
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_port      = w_sel;
               w_req.write = req_write[w_sel];
               w_req.addr  = w_addr_arr[w_sel];
               w_req.wdata = w_wdata_arr[w_sel];
               w_req.wstrb = w_wstrb_arr[w_sel];
               w_grant     = NUM_PORTS'(1) << w_sel;
               if (req_write[w_sel]) begin
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
                  w_state   = S_AWW;
               end else begin
                  w_arvalid = 1'b1;
                  w_arprot  = {INSTR_PORT_MASK[w_sel], 2'b00};
                  w_state   = S_AR;
               end
            end
         end
         S_AR: begin
            if (m_axi.arready) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = S_R;
            end
         end
         S_R: begin
            if (m_axi.rvalid) begin
               w_rready     = 1'b0;
               w_rdata      = m_axi.rdata;
               w_err        = m_axi.rresp[1];
               w_resp_valid = NUM_PORTS'(1) << r_port;
               w_state      = S_DONE;
            end
         end
         S_AWW: begin
            // Address and data channels retire independently.
            w_awvalid = r_awvalid & ~m_axi.awready;
            w_wvalid  = r_wvalid & ~m_axi.wready;
            if (!w_awvalid && !w_wvalid) begin
               w_bready = 1'b1;
               w_state  = S_B;
            end
         end
         S_B: begin
            if (m_axi.bvalid) begin
               w_bready     = 1'b0;
               w_rdata      = '0;
               w_err        = m_axi.bresp[1];
               w_resp_valid = NUM_PORTS'(1) << r_port;
               w_state      = S_DONE;
            end
         end
         S_DONE: begin
            w_resp_valid = '0;
            w_grant      = '0;
            w_ptr        = (r_port == PTR_W'(NUM_PORTS - 1)) ? '0 : r_port + PTR_W'(1);
            w_state      = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   logic w_unused;
   assign w_unused = ^{m_axi.rresp[0], m_axi.bresp[0]};

   assign m_axi.awvalid = r_awvalid;
   assign m_axi.awaddr  = r_req.addr;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.wdata   = r_req.wdata;
   assign m_axi.wstrb   = r_req.wstrb;
   assign m_axi.bready  = r_bready;
   assign m_axi.arvalid = r_arvalid;
   assign m_axi.araddr  = r_req.addr;
   assign m_axi.arprot  = r_arprot;
   assign m_axi.rready  = r_rready;

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   assign grant      = r_grant;
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with a response scoreboard and
// cycle-level checks on the AXI channel handshakes.
module tb_axi_lite_rr_arbiter;
   localparam int unsigned NP = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic              CLK;
   logic              RST;
   logic [NP-1:0]     req_valid;
   logic [NP-1:0]     req_write;
   logic [NP*AW-1:0]  req_addr;
   logic [NP*DW-1:0]  req_wdata;
   logic [NP*DW/8-1:0] req_wstrb;
   logic [NP-1:0]     resp_valid;
   logic [DW-1:0]     resp_rdata;
   logic              resp_err;
   logic [NP-1:0]     grant;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t sb[$];
   exp_t mon_e;

   axi_lite_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi_lite_rr_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_PORT_MASK(3'b001)
   ) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .grant(grant), .m_axi(axi)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input int p, input logic [31:0] d, input logic e);
      exp_t x;
      x.port  = p;
      x.rdata = d;
      x.err   = e;
      sb.push_back(x);
   endtask

   task automatic set_req(input int p, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      req_write[p]         = wr;
      req_addr[p*AW +: AW] = a;
      req_wdata[p*DW +: DW] = d;
      req_wstrb[p*4 +: 4]  = s;
      req_valid[p]         = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   // Scoreboard: every completion pulse must match the oldest expected entry.
   always @(negedge CLK) begin
      if (resp_valid != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 64'(resp_valid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("resp_valid", 64'(resp_valid), 64'(NP'(1) << mon_e.port));
            check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
            check("resp_err",   64'(resp_err),   64'(mon_e.err));
         end
      end
   end

   initial begin
      logic [NP-1:0] prev_grant;
      int            g_idx;
      int            n_resp;
      int            cnt [NP];
      int            order [6];

      RST = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
      repeat (3) tick();
      check("rst_grant",   64'(grant), 64'd0);
      check("rst_resp",    64'(resp_valid), 64'd0);
      check("rst_arvalid", 64'(axi.arvalid), 64'd0);
      check("rst_awvalid", 64'(axi.awvalid), 64'd0);
      check("rst_wvalid",  64'(axi.wvalid), 64'd0);
      check("rst_ready",   64'({axi.rready, axi.bready}), 64'd0);
      check("rst_rdata",   64'({resp_rdata, resp_err}), 64'd0);
      RST = 1'b0;
      tick();

      // Single read on instruction port 0 with ARREADY delayed two cycles.
      set_req(0, 1'b0, 32'h0000ABAC, 32'h0, 4'h0);
      push_exp(0, 32'hDEADAAAA, 1'b0);
      tick();
      check("t1_grant",   64'(grant), 64'(3'b001));
      check("t1_arvalid", 64'(axi.arvalid), 64'd1);
      check("t1_araddr",  64'(axi.araddr), 64'h0000ABAC);
      check("t1_arprot",  64'(axi.arprot), 64'(3'b100));
      check("t1_awvalid", 64'(axi.awvalid), 64'd0);
      tick(); tick();
      check("t1_arvalid_hold", 64'(axi.arvalid), 64'd1);
      check("t1_rready_low",   64'(axi.rready), 64'd0);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      check("t1_arvalid_drop", 64'(axi.arvalid), 64'd0);
      check("t1_rready",       64'(axi.rready), 64'd1);
      axi.rvalid = 1'b1; axi.rdata = 32'hDEADAAAA; axi.rresp = 2'b00;
      tick();
      axi.rvalid = 1'b0; axi.rdata = '0;
      check("t1_rready_off", 64'(axi.rready), 64'd0);
      req_valid[0] = 1'b0;
      tick();
      check("t1_pulse_once", 64'(resp_valid), 64'd0);
      check("t1_grant_idle", 64'(grant), 64'd0);
      drain("t1_drain");

      // Write from port 1 with W handshake before AW, slave error response.
      set_req(1, 1'b1, 32'h00000100, 32'h12345678, 4'b0011);
      push_exp(1, 32'h0, 1'b1);
      tick();
      check("t2_grant",   64'(grant), 64'(3'b010));
      check("t2_awvalid", 64'(axi.awvalid), 64'd1);
      check("t2_wvalid",  64'(axi.wvalid), 64'd1);
      check("t2_awaddr",  64'(axi.awaddr), 64'h100);
      check("t2_wdata",   64'(axi.wdata), 64'h12345678);
      check("t2_wstrb",   64'(axi.wstrb), 64'(4'b0011));
      check("t2_awprot",  64'(axi.awprot), 64'd0);
      check("t2_arvalid", 64'(axi.arvalid), 64'd0);
      axi.wready = 1'b1;
      tick();
      axi.wready = 1'b0;
      check("t2_wvalid_drop", 64'(axi.wvalid), 64'd0);
      check("t2_awvalid_hold", 64'(axi.awvalid), 64'd1);
      check("t2_bready_low",  64'(axi.bready), 64'd0);
      tick();
      check("t2_awvalid_hold2", 64'(axi.awvalid), 64'd1);
      axi.awready = 1'b1;
      tick();
      axi.awready = 1'b0;
      check("t2_awvalid_drop", 64'(axi.awvalid), 64'd0);
      check("t2_bready",       64'(axi.bready), 64'd1);
      axi.bvalid = 1'b1; axi.bresp = 2'b10;
      tick();
      axi.bvalid = 1'b0; axi.bresp = 2'b00;
      check("t2_bready_off", 64'(axi.bready), 64'd0);
      req_valid[1] = 1'b0; req_write[1] = 1'b0;
      tick();
      drain("t2_drain");

      // Write from port 2 with both READYs high in the first cycle.
      axi.awready = 1'b1; axi.wready = 1'b1;
      set_req(2, 1'b1, 32'h00000200, 32'hCAFEF00D, 4'b1111);
      push_exp(2, 32'h0, 1'b0);
      tick();
      check("t3_grant",  64'(grant), 64'(3'b100));
      check("t3_valids", 64'({axi.awvalid, axi.wvalid}), 64'(2'b11));
      tick();
      axi.awready = 1'b0; axi.wready = 1'b0;
      check("t3_valids_drop", 64'({axi.awvalid, axi.wvalid}), 64'd0);
      check("t3_bready",      64'(axi.bready), 64'd1);
      axi.bvalid = 1'b1;
      tick();
      axi.bvalid = 1'b0;
      req_valid[2] = 1'b0; req_write[2] = 1'b0;
      tick();
      drain("t3_drain");

      // Fairness: all ports read continuously against a zero-wait slave.
      order = '{0, 1, 2, 0, 1, 2};
      for (int i = 0; i < 6; i++)
         push_exp(order[i], {16'h1000 + 16'(order[i] * 16), 16'h5A5A}, 1'b0);
      for (int p = 0; p < int'(NP); p++) begin
         set_req(p, 1'b0, 32'h00001000 + 32'(p * 16), 32'h0, 4'h0);
         cnt[p] = 0;
      end
      axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rresp = 2'b00;
      prev_grant = '0; g_idx = 0; n_resp = 0;
      for (int cyc = 0; cyc < 100 && n_resp < 6; cyc++) begin
         tick();
         if (axi.arvalid) axi.rdata = {axi.araddr[15:0], 16'h5A5A};
         if (grant != '0 && prev_grant == '0) begin
            if (g_idx < 6) check("t4_grant_order", 64'(grant), 64'(NP'(1) << order[g_idx]));
            g_idx++;
         end
         prev_grant = grant;
         for (int p = 0; p < int'(NP); p++) begin
            if (resp_valid[p]) begin
               cnt[p]++;
               n_resp++;
               if (cnt[p] == 2) req_valid[p] = 1'b0;
            end
         end
      end
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
      check("t4_grant_count", 64'(g_idx), 64'd6);
      drain("t4_drain");

      // Request inputs changed after grant must not affect the transfer.
      set_req(0, 1'b0, 32'h00000040, 32'h0, 4'h0);
      push_exp(0, 32'h11112222, 1'b1);
      tick();
      check("t5_araddr", 64'(axi.araddr), 64'h40);
      req_addr[0 +: AW] = 32'h0000FFF0;
      req_write[0] = 1'b1;
      tick();
      check("t5_araddr_latched", 64'(axi.araddr), 64'h40);
      check("t5_arvalid_hold",   64'(axi.arvalid), 64'd1);
      check("t5_no_write",       64'(axi.awvalid), 64'd0);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      axi.rvalid = 1'b1; axi.rdata = 32'h11112222; axi.rresp = 2'b10;
      tick();
      axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
      req_valid[0] = 1'b0; req_write[0] = 1'b0;
      tick();
      drain("t5_drain");

      // Reset while waiting in R aborts silently; pointer returns to port 0.
      axi.arready = 1'b1;
      set_req(1, 1'b0, 32'h00000300, 32'h0, 4'h0);
      tick();
      tick();
      axi.arready = 1'b0;
      check("t6_rready_before", 64'(axi.rready), 64'd1);
      RST = 1'b1;
      tick();
      check("t6_rready_rst", 64'(axi.rready), 64'd0);
      check("t6_grant_rst",  64'(grant), 64'd0);
      check("t6_resp_rst",   64'(resp_valid), 64'd0);
      RST = 1'b0;
      req_valid[1] = 1'b0;
      set_req(2, 1'b0, 32'h000002C0, 32'h0, 4'h0);
      push_exp(2, 32'h0BADCAFE, 1'b0);
      axi.arready = 1'b1;
      tick();
      check("t6_grant_p2", 64'(grant), 64'(3'b100));
      check("t6_arprot",   64'(axi.arprot), 64'd0);
      tick();
      axi.arready = 1'b0;
      axi.rvalid = 1'b1; axi.rdata = 32'h0BADCAFE;
      tick();
      axi.rvalid = 1'b0; axi.rdata = '0;
      req_valid[2] = 1'b0;
      tick();
      drain("t6_drain");

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
